// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart_tx packet arbiter.
// Optional source tag header: UART_TX_ARBITER_SRC_TAG_EN.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAG,
        S_LOAD,
        S_SEND,
        S_WAIT
    } state_t;

    localparam logic [3:0] TAG_HI = 4'hA;

    function automatic int cnt_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Round-robin priority search starting after the last owner.
// Pointer is updated only when a packet grant is released.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic               i_Clock,
    input  logic               i_Reset,
    input  logic [NUM_REQ-1:0] i_Req,
    input  logic               i_Upd,
    input  logic [IW-1:0]      i_Upd_Idx,
    output logic               o_Any,
    output logic [IW-1:0]      o_Idx
);

    localparam logic [IW:0] N_C = (IW+1)'(NUM_REQ);

    logic [IW-1:0] r_Ptr;
    logic [IW:0]   w_Pos;

    always_comb begin
        o_Any = 1'b0;
        o_Idx = '0;
        w_Pos = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_Pos = {1'b0, r_Ptr} + (IW+1)'(i);
            if (w_Pos >= N_C)
                w_Pos = w_Pos - N_C;
            if (!o_Any && i_Req[w_Pos[IW-1:0]]) begin
                o_Any = 1'b1;
                o_Idx = w_Pos[IW-1:0];
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset)
            r_Ptr <= IW'(NUM_REQ - 1);
        else if (i_Upd)
            r_Ptr <= i_Upd_Idx;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one uart_tx serializer.
// Define UART_TX_ARBITER_SRC_TAG_EN to prefix each grant with {A, idx}.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MAX_PKT_LEN = 64
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [NUM_REQ-1:0]   i_Req_Valid,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    input  logic [NUM_REQ-1:0]   i_Req_Last,
    output logic [NUM_REQ-1:0]   o_Req_Ready,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic                 o_Busy,
    output logic                 o_Overrun
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = cnt_width(MAX_PKT_LEN);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_PKT_LEN);

    state_t        r_State;
    logic [IW-1:0] r_Idx;
    logic [CW-1:0] r_Cnt;
    logic          r_Last;
`ifdef UART_TX_ARBITER_SRC_TAG_EN
    logic          r_Tag;
`endif

    logic               w_Any;
    logic [IW-1:0]      w_Win_Idx;
    logic [NUM_REQ-1:0] w_Win_Oh;
    logic               w_Xfer;
    logic [7:0]         w_Byte;
    logic               w_Last;
    logic               w_Rel;
    logic               w_Tag_Done;

    assign w_Win_Oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_Win_Idx;
    assign w_Xfer   = |(i_Req_Valid & o_Req_Ready);
    assign w_Byte   = i_Req_Byte[{r_Idx, 3'b000} +: 8];
    assign w_Last   = i_Req_Last[r_Idx];
`ifdef UART_TX_ARBITER_SRC_TAG_EN
    assign w_Tag_Done = r_Tag;
`else
    assign w_Tag_Done = 1'b0;
`endif
    assign w_Rel = (r_State == S_WAIT) && i_Tx_Done && !w_Tag_Done
                && (r_Last || r_Cnt == MAX_C);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_Clock   (i_Clock),
        .i_Reset   (i_Reset),
        .i_Req     (i_Req_Valid),
        .i_Upd     (w_Rel),
        .i_Upd_Idx (r_Idx),
        .o_Any     (w_Any),
        .o_Idx     (w_Win_Idx)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_State     <= S_IDLE;
            r_Idx       <= '0;
            r_Cnt       <= '0;
            r_Last      <= 1'b0;
            o_Req_Ready <= '0;
            o_Grant     <= '0;
            o_Tx_DV     <= 1'b0;
            o_Tx_Byte   <= 8'h00;
            o_Busy      <= 1'b0;
            o_Overrun   <= 1'b0;
`ifdef UART_TX_ARBITER_SRC_TAG_EN
            r_Tag       <= 1'b0;
`endif
        end else begin
            o_Tx_DV   <= 1'b0;
            o_Overrun <= 1'b0;
            unique case (r_State)
                // serializer has no reset: never start while it is mid-frame
                S_IDLE: begin
                    if (!i_Tx_Active && w_Any) begin
                        o_Grant <= w_Win_Oh;
                        r_Idx   <= w_Win_Idx;
                        o_Busy  <= 1'b1;
`ifdef UART_TX_ARBITER_SRC_TAG_EN
                        r_State <= S_TAG;
`else
                        r_State     <= S_LOAD;
                        o_Req_Ready <= w_Win_Oh;
`endif
                    end
                end
`ifdef UART_TX_ARBITER_SRC_TAG_EN
                S_TAG: begin
                    o_Tx_Byte <= {TAG_HI, 4'(r_Idx)};
                    o_Tx_DV   <= 1'b1;
                    r_Tag     <= 1'b1;
                    r_State   <= S_SEND;
                end
`endif
                S_LOAD: begin
                    if (w_Xfer) begin
                        o_Tx_Byte   <= w_Byte;
                        r_Last      <= w_Last;
                        o_Req_Ready <= '0;
                        r_Cnt       <= r_Cnt + 1'b1;
                        o_Tx_DV     <= 1'b1;
                        r_State     <= S_SEND;
                    end
                end
                S_SEND: r_State <= S_WAIT;
                S_WAIT: begin
                    if (i_Tx_Done) begin
                        if (w_Rel) begin
                            r_State   <= S_IDLE;
                            r_Cnt     <= '0;
                            o_Grant   <= '0;
                            o_Busy    <= 1'b0;
                            o_Overrun <= !r_Last;
                        end else begin
                            r_State     <= S_LOAD;
                            o_Req_Ready <= o_Grant;
                        end
`ifdef UART_TX_ARBITER_SRC_TAG_EN
                        r_Tag <= 1'b0;
`endif
                    end
                end
                default: r_State <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised + directed bench for uart_tx_arbiter with a uart_tx model.
// Reference: per-requester byte streams and packet-length arithmetic.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int MAXL  = 4;
    localparam int FRAME = 10;

    logic           clk = 1'b0;
    logic           i_Reset = 1'b1;
    logic [N-1:0]   i_Req_Valid = '0;
    logic [8*N-1:0] i_Req_Byte = '0;
    logic [N-1:0]   i_Req_Last = '0;
    logic [N-1:0]   o_Req_Ready;
    logic [N-1:0]   o_Grant;
    logic           o_Tx_DV;
    logic [7:0]     o_Tx_Byte;
    logic           i_Tx_Active = 1'b0;
    logic           i_Tx_Done = 1'b0;
    logic           o_Busy;
    logic           o_Overrun;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .MAX_PKT_LEN(MAXL)) dut (
        .i_Clock     (clk),
        .i_Reset     (i_Reset),
        .i_Req_Valid (i_Req_Valid),
        .i_Req_Byte  (i_Req_Byte),
        .i_Req_Last  (i_Req_Last),
        .o_Req_Ready (o_Req_Ready),
        .o_Grant     (o_Grant),
        .o_Tx_DV     (o_Tx_DV),
        .o_Tx_Byte   (o_Tx_Byte),
        .i_Tx_Active (i_Tx_Active),
        .i_Tx_Done   (i_Tx_Done),
        .o_Busy      (o_Busy),
        .o_Overrun   (o_Overrun)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int oh2idx(logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    // uart_tx model: busy FRAME cycles after a start, then a done pulse
    int tx_left = 0;
    always @(posedge clk) begin
        if (tx_left == 0) begin
            i_Tx_Done <= 1'b0;
            if (o_Tx_DV) begin
                i_Tx_Active <= 1'b1;
                tx_left     <= FRAME;
            end
        end else if (tx_left == 1) begin
            tx_left     <= 0;
            i_Tx_Active <= 1'b0;
            i_Tx_Done   <= 1'b1;
        end else begin
            tx_left <= tx_left - 1;
        end
    end

    // monitor
    int         cyc = 0;
    int         dv_all[$];
    int         done_log[$];
    int         pl_idx[$];
    logic [7:0] pl_byte[$];
    int         pl_cyc[$];
    int         ovr_cnt = 0;
    int         ovr_cyc = 0;
    int         tag_cnt = 0;
    logic [7:0] last_tag = 8'h00;
    bit         seg_new = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (i_Tx_Done) done_log.push_back(cyc);
        if (o_Overrun) begin
            ovr_cnt++;
            ovr_cyc = cyc;
        end
        if (o_Grant == '0) seg_new = 1'b1;
        if (o_Tx_DV) begin
            dv_all.push_back(cyc);
            chk("dv_grant_onehot", 32'($onehot(o_Grant)), 1);
`ifdef UART_TX_ARBITER_SRC_TAG_EN
            if (seg_new) begin
                tag_cnt++;
                last_tag = o_Tx_Byte;
                chk("tag_byte", 32'(o_Tx_Byte),
                    {24'h0, 4'hA, 4'(oh2idx(o_Grant))});
            end else
`endif
            begin
                pl_idx.push_back(oh2idx(o_Grant));
                pl_byte.push_back(o_Tx_Byte);
                pl_cyc.push_back(cyc);
            end
            seg_new = 1'b0;
        end
    end

    // requester sources
    logic [8:0] rq[N][$];
    logic [7:0] exp_q[N][$];
    int         plen[N];
    bit         hold[N];
    bit         stall_en = 1'b0;
    int         exp_ovr = 0;
    int         exp_seg = 0;

    task automatic push_byte(int r, logic [7:0] b, bit last);
        rq[r].push_back({last, b});
        exp_q[r].push_back(b);
        plen[r]++;
        if (last) begin
            exp_ovr += (plen[r] - 1) / MAXL;
            exp_seg += (plen[r] - 1) / MAXL + 1;
            plen[r] = 0;
        end
    endtask

    task automatic push_run(int r, int len, logic [7:0] b0, bit rnd);
        for (int k = 0; k < len; k++)
            push_byte(r, rnd ? 8'($urandom) : b0 + 8'(k), k == len - 1);
    endtask

    function automatic bit all_empty();
        for (int r = 0; r < N; r++)
            if (rq[r].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        logic [N-1:0] xm;
        forever begin
            @(negedge clk);
            xm = i_Req_Valid & o_Req_Ready;
            @(posedge clk);
            #1;
            for (int r = 0; r < N; r++) begin
                if (xm[r] && rq[r].size() != 0)
                    void'(rq[r].pop_front());
                if (rq[r].size() != 0 && !hold[r]
                    && !(stall_en && $urandom_range(0, 3) == 0)) begin
                    i_Req_Valid[r]     = 1'b1;
                    i_Req_Byte[8*r +: 8] = rq[r][0][7:0];
                    i_Req_Last[r]      = rq[r][0][8];
                end else begin
                    i_Req_Valid[r]     = 1'b0;
                    i_Req_Byte[8*r +: 8] = 8'($urandom);
                    i_Req_Last[r]      = 1'($urandom);
                end
            end
        end
    end

    task automatic wait_idle(int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (all_empty() && !o_Busy && !i_Tx_Active && tx_left == 0)
                break;
        end
        chk("idle_timeout", 32'(k >= budget), 0);
    endtask

    task automatic wait_pl(int base, int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (pl_idx.size() > base) break;
        end
        chk("payload_timeout", 32'(k >= budget), 0);
    endtask

    initial begin
        int base, n0, d0, k, cnt, p4, dn, pre;
        logic [7:0] b;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(o_Req_Ready), 0);
        chk("rst_grant", 32'(o_Grant), 0);
        chk("rst_dv", 32'(o_Tx_DV), 0);
        chk("rst_byte", 32'(o_Tx_Byte), 0);
        chk("rst_busy", 32'(o_Busy), 0);
        chk("rst_ovr", 32'(o_Overrun), 0);
        i_Reset = 1'b0;
        repeat (2) @(negedge clk);

        // two-byte packet, latency and back-to-back gap
        base = pl_idx.size();
        n0 = dv_all.size();
        d0 = done_log.size();
        push_byte(0, 8'h55, 1'b0);
        push_byte(0, 8'hAA, 1'b1);
        for (k = 1; k < 50; k++) begin
            @(negedge clk);
            if (o_Tx_DV) break;
        end
        chk("latency", k, 3);
        wait_idle(500);
        chk("t1_count", pl_idx.size() - base, 2);
        chk("t1_b0", 32'(pl_byte[base]), 8'h55);
        chk("t1_b1", 32'(pl_byte[base+1]), 8'hAA);
        chk("t1_g0", pl_idx[base], 0);
        chk("t1_g1", pl_idx[base+1], 0);
        chk("t1_gap", dv_all[n0+1] - done_log[d0], 2);
        chk("t1_grant_end", 32'(o_Grant), 0);

        // simultaneous requests, then everyone after pointer=3
        base = pl_idx.size();
        push_byte(1, 8'h11, 1'b1);
        push_byte(3, 8'h33, 1'b1);
        wait_idle(500);
        chk("t2_first", pl_idx[base], 1);
        chk("t2_second", pl_idx[base+1], 3);
        base = pl_idx.size();
        for (int r = 0; r < N; r++) push_byte(r, 8'h40 + 8'(r), 1'b1);
        wait_idle(1000);
        for (int r = 0; r < N; r++)
            chk($sformatf("t2_all%0d", r), pl_idx[base+r], r);

        // owner stalls mid-packet while requester 2 waits
        base = pl_idx.size();
        push_run(0, 3, 8'h01, 1'b0);
        push_byte(2, 8'h22, 1'b1);
        wait_pl(base, 100);
        hold[0] = 1'b1;
        n0 = dv_all.size();
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (o_Grant != 4'b0001) cnt++;
        end
        chk("t3_dv_held", dv_all.size() - n0, 0);
        chk("t3_grant_held", cnt, 0);
        hold[0] = 1'b0;
        wait_idle(1000);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("t3_g%0d", j), pl_idx[base+j], 0);
            chk($sformatf("t3_b%0d", j), 32'(pl_byte[base+j]), 8'h01 + j);
        end
        chk("t3_g3", pl_idx[base+3], 2);

        // forced release after MAX_PKT_LEN bytes
        base = pl_idx.size();
        cnt = ovr_cnt;
        push_run(0, 6, 8'h60, 1'b0);
        wait_idle(1500);
        chk("t4_ovr_once", ovr_cnt - cnt, 1);
        chk("t4_count", pl_idx.size() - base, 6);
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("t4_g%0d", j), pl_idx[base+j], 0);
            chk($sformatf("t4_b%0d", j), 32'(pl_byte[base+j]), 8'h60 + j);
        end
        p4 = pl_cyc[base+3];
        dn = -1;
        foreach (done_log[j])
            if (dn < 0 && done_log[j] > p4) dn = done_log[j];
        chk("t4_ovr_cycle", ovr_cyc, dn + 1);

        // reset while the serializer is mid-frame
        base = pl_idx.size();
        n0 = dv_all.size();
        push_run(1, 3, 8'h71, 1'b0);
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (dv_all.size() > n0) break;
        end
        chk("t5_start_timeout", 32'(k >= 50), 0);
        repeat (2) @(negedge clk);
        push_byte(2, 8'h81, 1'b1);
        i_Reset = 1'b1;
        @(negedge clk);
        i_Reset = 1'b0;
        pre = 0;
        for (int j = base; j < pl_idx.size(); j++)
            if (pl_idx[j] == 1) pre++;
        exp_seg++;
        chk("t5_grant", 32'(o_Grant), 0);
        chk("t5_busy", 32'(o_Busy), 0);
        chk("t5_ready", 32'(o_Req_Ready), 0);
        cnt = 0;
        for (k = 0; k < 100; k++) begin
            if (!i_Tx_Active) break;
            if (o_Tx_DV) cnt++;
            @(negedge clk);
        end
        chk("t5_dv_while_active", cnt, 0);
        chk("t5_active_timeout", 32'(k >= 100), 0);
        wait_idle(1000);
        chk("t5_resume_g", pl_idx[base+pre], 1);
        chk("t5_resume_b", 32'(pl_byte[base+pre]), 8'h71 + pre);

        // single byte from requester 2
        base = pl_idx.size();
        push_byte(2, 8'h3C, 1'b1);
        wait_idle(500);
        chk("t6_g", pl_idx[base], 2);
        chk("t6_b", 32'(pl_byte[base]), 8'h3C);
`ifdef UART_TX_ARBITER_SRC_TAG_EN
        chk("t6_tag", 32'(last_tag), 8'hA2);
`endif

        // random traffic with source stalls
        stall_en = 1'b1;
        for (int p = 0; p < 30; p++) begin
            repeat ($urandom_range(1, 8)) @(negedge clk);
            push_run($urandom_range(0, N - 1), $urandom_range(1, 7), 8'h00, 1'b1);
        end
        wait_idle(30000);
        stall_en = 1'b0;

        // whole-run scoreboard
        for (int r = 0; r < N; r++) begin
            k = 0;
            for (int j = 0; j < pl_idx.size(); j++) begin
                if (pl_idx[j] == r) begin
                    b = (k < exp_q[r].size()) ? exp_q[r][k] : 8'hxx;
                    chk($sformatf("stream_r%0d_%0d", r, k), 32'(pl_byte[j]), 32'(b));
                    k++;
                end
            end
            chk($sformatf("stream_len_r%0d", r), k, exp_q[r].size());
        end
        chk("ovr_total", ovr_cnt, exp_ovr);
`ifdef UART_TX_ARBITER_SRC_TAG_EN
        chk("tag_total", tag_cnt, exp_seg);
`endif
        chk("end_grant", 32'(o_Grant), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between NUM_REQ byte-stream requesters. Each requester delivers a packet as a stream of bytes ending with a last flag.
- Arbitration is round-robin at packet granularity. A grant is held until the packet's last byte has fully left the serializer.
- The block sits between the requester logic and uart_tx. It drives uart_tx's data-valid/byte inputs and consumes its active/done outputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- MAX_PKT_LEN, 64, maximum payload bytes per grant before a forced release (1..255).

Ports:
- i_Clock  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Req_Valid  in  NUM_REQ  requester r has a byte available.
- i_Req_Byte  in  8*NUM_REQ  byte of requester r is bits [8r+7:8r].
- i_Req_Last  in  NUM_REQ  the byte offered by requester r is the last of its packet.
- o_Req_Ready  out  NUM_REQ  one-hot; a byte transfers on a cycle where valid and ready are both high.
- o_Grant  out  NUM_REQ  one-hot owner of the serializer; all zero when idle.
- o_Tx_DV  out  1  one-cycle start pulse to uart_tx i_Tx_DV.
- o_Tx_Byte  out  8  byte to uart_tx i_Tx_Byte.
- i_Tx_Active  in  1  from uart_tx o_Tx_Active.
- i_Tx_Done  in  1  from uart_tx o_Tx_Done (one-cycle pulse).
- o_Busy  out  1  high whenever the state is not S_IDLE.
- o_Overrun  out  1  one-cycle pulse on a forced release at MAX_PKT_LEN.

Behaviour:
- All outputs are registered.
- Reset values: o_Req_Ready=0, o_Grant=0, o_Tx_DV=0, o_Tx_Byte=8'h00, o_Busy=0, o_Overrun=0, rr pointer=NUM_REQ-1, byte count=0, state=S_IDLE.

State machine:
- S_IDLE: arbitrate only when i_Tx_Active==0. The serializer has no reset, so after a reset mid-frame the block must wait for it to go idle.
  - The winner is the first r with i_Req_Valid[r], searching from rr pointer+1 upward with wrap to 0.
  - Register o_Grant one-hot, then go to S_LOAD (or S_TAG when the optional feature is compiled in).
- S_LOAD: drive o_Req_Ready[g]=1 while waiting.
  - On valid&ready, latch the byte into o_Tx_Byte and latch last into an internal flag.
  - Drop ready on the next cycle, so at most one byte is accepted per visit. Increment the byte count, then go to S_SEND.
  - If the owner holds valid low, wait indefinitely and keep the grant.
- S_SEND: o_Tx_DV=1 for exactly this cycle, then go to S_WAIT.
- S_WAIT: o_Tx_Byte is held stable. Exit on i_Tx_Done:
  - If last is set: go to S_IDLE, set rr pointer=g, clear the byte count and o_Grant.
  - Else if byte count==MAX_PKT_LEN: same as the last-byte exit, plus pulse o_Overrun. The requester's remaining bytes are arbitrated later as a new packet.
  - Otherwise: go to S_LOAD.

Timing and fairness:
- Latency: with the serializer idle and requester valid, o_Tx_DV rises in the 3rd cycle, counting the S_IDLE arbitration cycle as cycle 1.
- Back-to-back bytes: the gap from i_Tx_Done to the next o_Tx_DV is 2 cycles (S_LOAD, S_SEND).
- Simultaneous requests go to the requester nearest after the previous owner. No requester waits more than NUM_REQ-1 packets.
- A requester dropping valid while not granted is ignored. Changes to its byte or last while not granted are likewise ignored.
- i_Tx_Done outside S_WAIT is ignored.
- i_Reset mid-packet aborts the packet and clears the grant. The interrupted requester restarts its packet on its own.

Optional Feature:
- Macro: UART_TX_ARBITER_SRC_TAG_EN.
- When defined, state S_TAG sits between S_IDLE and S_LOAD. It sends a header byte {4'hA, grant index[3:0]} through its own S_SEND/S_WAIT sequence, with no requester handshake and no byte-count increment, then goes to S_LOAD.
- When undefined, S_TAG does not exist and only payload bytes are sent.

Decomposition:
- Package uart_arb_pkg holds:
  - the state enum (S_IDLE, S_TAG, S_LOAD, S_SEND, S_WAIT);
  - the tag nibble constant TAG_HI=4'hA;
  - a width function for the byte counter.
- Sub-module rr_arbiter (combinational priority search plus registered pointer update, parameterised by NUM_REQ) is the natural split.

Test Plan:
- Reset, then requester 0 sends 2 bytes 8'h55, 8'hAA (last on 8'hAA) -> exactly two o_Tx_DV pulses, o_Tx_Byte 8'h55 then 8'hAA, o_Grant=4'b0001 throughout, o_Grant=0 after the 2nd done.
- Requesters 1 and 3 assert valid in the same cycle, each with a 1-byte packet -> 1 served first, then 3. With the pointer then at 3 and all four requesting, the order is 0, 1, 2, 3.
- Owner drops valid for 100 cycles mid-packet while requester 2 is requesting -> grant held, no o_Tx_DV and no grant to 2 until the owner resumes.
- MAX_PKT_LEN=4, requester 0 offers 6 bytes with last on the 6th -> o_Overrun pulses once after the 4th done. Arbitration then reruns and requester 0 sends 2 more bytes.
- Assert i_Reset while the model uart_tx is mid data bit (i_Tx_Active=1) with requests pending -> no o_Tx_DV until i_Tx_Active falls, then normal arbitration.
- Tag enabled, requester 2 sends 1 byte 8'h3C -> serial stream carries 8'hA2 then 8'h3C.
